// File: rtl/gctr_frame_sequencer_if.sv
// Handshake and data bundle between an upstream word source and the GCTR frame sequencer.
// Slave is the sequencer side; master is the upstream/test side.
interface gctr_frame_sequencer_if #(
   parameter int NB_BLOCK = 128,
   parameter int N_BLOCKS = 2,
   parameter int NB_DATA  = N_BLOCKS*NB_BLOCK,
   parameter int NB_IV    = 96
);
   logic [NB_DATA-1:0]  i_data;
   logic [NB_IV-1:0]    i_iv;
   logic                i_sof;
   logic                i_eof;
   logic                i_valid;
   logic                o_ready;
   logic [NB_DATA-1:0]  o_plaintext_words_x;
   logic [NB_BLOCK-1:0] o_initial_counter_block;
   logic                o_sop;
   logic                o_sop_pre;
   logic [NB_DATA-1:0]  o_pre_blocks;
   logic                o_valid;
   logic                o_eop;
   logic                o_err;

   modport slave (
      input  i_data, i_iv, i_sof, i_eof, i_valid,
      output o_ready, o_plaintext_words_x, o_initial_counter_block, o_sop,
             o_sop_pre, o_pre_blocks, o_valid, o_eop, o_err
   );

   modport master (
      output i_data, i_iv, i_sof, i_eof, i_valid,
      input  o_ready, o_plaintext_words_x, o_initial_counter_block, o_sop,
             o_sop_pre, o_pre_blocks, o_valid, o_eop, o_err
   );
endinterface

// File: rtl/gctr_frame_sequencer.sv
// Frames upstream plaintext words for a GCTR stage: inserts one pre-block cycle
// (zero block for H, J0 for the tag mask) ahead of each frame and supplies inc32(J0).
module gctr_frame_sequencer #(
   parameter int          NB_BLOCK    = 128,
   parameter int          N_BLOCKS    = 2,
   parameter int          NB_DATA     = N_BLOCKS*NB_BLOCK,
   parameter int          NB_IV       = 96,
   parameter logic [31:0] J0_LOW_WORD = 32'h0000_0001
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   gctr_frame_sequencer_if.slave  bus
);
   localparam int NB_CTR = NB_BLOCK - NB_IV;

   typedef enum logic [1:0] {IDLE, PRE, OPEN} state_t;

   state_t              state_reg, state_next;
   logic [NB_DATA-1:0]  hold_data_reg, hold_data_next;
   logic                hold_eof_reg, hold_eof_next;
   logic                ready_reg, ready_next;
   logic [NB_DATA-1:0]  data_reg, data_next;
   logic [NB_BLOCK-1:0] icb_reg, icb_next;
   logic [NB_DATA-1:0]  pre_reg, pre_next;
   logic                sop_pre_reg, sop_pre_next;
   logic                valid_reg, valid_next;
   logic                sop_reg, sop_next;
   logic                eop_reg, eop_next;
   logic                err_reg, err_next;

   logic                accept;
   logic                start;
   logic [NB_CTR-1:0]   j0_low;
   logic [NB_CTR-1:0]   icb_low;

   assign accept  = bus.i_valid & ready_reg;
   assign j0_low  = J0_LOW_WORD[NB_CTR-1:0];
   assign icb_low = j0_low + 1'b1;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      start          = 1'b0;
      hold_data_next = hold_data_reg;
      hold_eof_next  = hold_eof_reg;
      data_next      = data_reg;
      icb_next       = icb_reg;
      pre_next       = '0;
      sop_pre_next   = 1'b0;
      valid_next     = 1'b0;
      sop_next       = 1'b0;
      eop_next       = 1'b0;
      err_next       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (bus.i_sof) start = 1'b1;
               else           err_next = 1'b1;
            end
         end
         PRE: begin
            valid_next = 1'b1;
            sop_next   = 1'b1;
            eop_next   = hold_eof_reg;
            data_next  = hold_data_reg;
            state_next = hold_eof_reg ? IDLE : OPEN;
         end
         OPEN: begin
            if (accept) begin
               if (bus.i_sof) begin
                  // New SOF aborts the open frame; no eop is ever issued for it.
                  err_next = 1'b1;
                  start    = 1'b1;
               end else begin
                  valid_next = 1'b1;
                  data_next  = bus.i_data;
                  eop_next   = bus.i_eof;
                  if (bus.i_eof) state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (start) begin
         state_next     = PRE;
         hold_data_next = bus.i_data;
         hold_eof_next  = bus.i_eof;
         icb_next       = {bus.i_iv, icb_low};
         sop_pre_next   = 1'b1;
         pre_next[2*NB_BLOCK-1:NB_BLOCK] = {bus.i_iv, j0_low};
      end

      ready_next = (state_next != PRE);
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hold_data_reg <= '0;
         hold_eof_reg  <= 1'b0;
         ready_reg     <= 1'b1;
         data_reg      <= '0;
         icb_reg       <= '0;
         pre_reg       <= '0;
         sop_pre_reg   <= 1'b0;
         valid_reg     <= 1'b0;
         sop_reg       <= 1'b0;
         eop_reg       <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         hold_data_reg <= hold_data_next;
         hold_eof_reg  <= hold_eof_next;
         ready_reg     <= ready_next;
         data_reg      <= data_next;
         icb_reg       <= icb_next;
         pre_reg       <= pre_next;
         sop_pre_reg   <= sop_pre_next;
         valid_reg     <= valid_next;
         sop_reg       <= sop_next;
         eop_reg       <= eop_next;
         err_reg       <= err_next;
      end
   end

   assign bus.o_ready                 = ready_reg;
   assign bus.o_plaintext_words_x     = data_reg;
   assign bus.o_initial_counter_block = icb_reg;
   assign bus.o_pre_blocks            = pre_reg;
   assign bus.o_sop_pre               = sop_pre_reg;
   assign bus.o_valid                 = valid_reg;
   assign bus.o_sop                   = sop_reg;
   assign bus.o_eop                   = eop_reg;
   assign bus.o_err                   = err_reg;
endmodule
